// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared encodings and widths for the instruction trace buffer
package trace_pkg;

    localparam int PC_W    = 32;
    localparam int ENTRY_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - first-word-fall-through FIFO with overwrite-oldest strobe
module trace_fifo #(
    parameter int  DEPTH   = 16,
    parameter int  ENTRY_W = 64,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic               ovw_en,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [ENTRY_W-1:0] rd_data,
    output logic               rd_valid,
    output logic               full,
    output logic [AW:0]        count
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic               adv_rd;

    // An overwrite retires the oldest entry exactly like a pop does.
    assign adv_rd   = rd_en | ovw_en;
    assign rd_data  = mem[rd_ptr];
    assign rd_valid = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));

    // Storage array; contents are meaningless until count says otherwise, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count disambiguates full from empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, adv_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_trace_buffer.sv
// rtl/instr_trace_buffer.sv - PC-triggered {pc, instr} capture into a readable FIFO (option: TRACE_WRAP_EN)
module instr_trace_buffer
    import trace_pkg::*;
#(
    parameter int  DEPTH  = 16,
    parameter int  DROP_W = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               stop,
    input  logic               clear,
    input  logic               trig_any,
    input  logic [PC_W-1:0]    trig_pc,
    input  logic [PC_W-1:0]    pc_i,
    input  logic [PC_W-1:0]    instr_i,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ENTRY_W-1:0] rd_data,
    output logic [AW:0]        count,
    output logic [1:0]         state_o,
    output logic               overflow,
    output logic [DROP_W-1:0]  drop_cnt
);

    trace_state_t state;
    trace_state_t state_nx;
    logic         sample;
    logic         pop;
    logic         full;
    logic         drop;
    logic         wr_en;
    logic         ovw_en;

    assign state_o = state;
    assign pop     = rd_valid & rd_ready & ~clear;
    assign drop    = sample & full & ~pop;

`ifdef TRACE_WRAP_EN
    // Keep the newest samples: a blocked write pushes out the oldest entry.
    assign wr_en  = sample;
    assign ovw_en = drop;
`else
    // Keep the oldest samples: a blocked write is simply discarded.
    assign wr_en  = sample & ~drop;
    assign ovw_en = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and capture request; clear beats stop beats arm beats trigger.
    always_comb begin
        state_nx = state;
        sample   = 1'b0;
        if (clear) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!stop && arm) state_nx = ST_ARMED;
                end
                ST_ARMED: begin
                    if (stop) begin
                        state_nx = ST_IDLE;
                    end else if (!arm && (trig_any || pc_i == trig_pc)) begin
                        state_nx = ST_CAPTURE;
                        sample   = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    sample = 1'b1;
                    if (stop) state_nx = ST_DONE;
                end
                ST_DONE: begin
                    if (!stop && arm) state_nx = ST_ARMED;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + DROP_W'(1);
            end
        end
    end

    trace_fifo #(
        .DEPTH   (DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .wr_en    (wr_en),
        .rd_en    (pop),
        .ovw_en   (ovw_en),
        .wr_data  ({pc_i, instr_i}),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .full     (full),
        .count    (count)
    );

endmodule

// File: tb/tb_instr_trace_buffer.sv
// tb/tb_instr_trace_buffer.sv - randomized self-checking bench for instr_trace_buffer
module tb_instr_trace_buffer;

    localparam int DEPTH  = 16;
    localparam int AW     = $clog2(DEPTH);
    localparam int DROP_W = 4;
    localparam int DROP_MAX = (1 << DROP_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              arm = 1'b0;
    logic              stop = 1'b0;
    logic              clear = 1'b0;
    logic              trig_any = 1'b0;
    logic [31:0]       trig_pc = '0;
    logic [31:0]       pc_i = '0;
    logic [31:0]       instr_i = '0;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [63:0]       rd_data;
    logic [AW:0]       count;
    logic [1:0]        state_o;
    logic              overflow;
    logic [DROP_W-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference: trace as a queue, phase as 0..3, flags as plain values.
    logic [63:0] mq[$];
    int          mst = 0;
    bit          movf = 0;
    int          mdrops = 0;

    instr_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk(clk), .reset(reset), .arm(arm), .stop(stop), .clear(clear),
        .trig_any(trig_any), .trig_pc(trig_pc), .pc_i(pc_i), .instr_i(instr_i),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .state_o(state_o), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        mst = 0;
        movf = 0;
        mdrops = 0;
    endtask

    // Advance the reference by one cycle using the inputs the DUT sees, then clock.
    task automatic step();
        bit pop;
        bit wr;
        pop = (mq.size() > 0) && rd_ready && !clear;
        wr = 0;
        if (clear) begin
            model_reset();
        end else begin
            if (mst == 0) begin
                if (!stop && arm) mst = 1;
            end else if (mst == 1) begin
                if (stop) mst = 0;
                else if (!arm && (trig_any || pc_i == trig_pc)) begin mst = 2; wr = 1; end
            end else if (mst == 2) begin
                wr = 1;
                if (stop) mst = 3;
            end else begin
                if (!stop && arm) mst = 1;
            end
            if (pop) void'(mq.pop_front());
            if (wr) begin
                if (mq.size() < DEPTH) begin
                    mq.push_back({pc_i, instr_i});
                end else begin
                    movf = 1;
                    if (mdrops < DROP_MAX) mdrops++;
`ifdef TRACE_WRAP_EN
                    void'(mq.pop_front());
                    mq.push_back({pc_i, instr_i});
`endif
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        arm = 0; stop = 0; clear = 0; rd_ready = 0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clear = 1;
        step();
        clear = 0;
    endtask

    task automatic do_arm();
        arm = 1;
        step();
        arm = 0;
    endtask

    task automatic test_reset();
        reset = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state_o !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0) begin
            failures++;
            $display("FAIL reset: state=%0d count=%0d valid=%b ovf=%b drops=%0d required 0/0/0/0/0",
                     state_o, count, rd_valid, overflow, drop_cnt);
        end
        reset = 1;
        model_reset();
    endtask

    task automatic test_trig_any();
        do_clear();
        trig_any = 1;
        pc_i = 32'h100;
        do_arm();
        for (int k = 0; k < 6; k++) begin
            pc_i = 32'(k * 4);
            instr_i = $urandom;
            stop = (k == 5);
            step();
        end
        stop = 0;
        checks++;
        if (count !== 5'd6 || state_o !== 2'd3) begin
            failures++;
            $display("FAIL trig_any_count: count=%0d state=%0d required 6/3", count, state_o);
        end
        rd_ready = 1;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data[63:32] !== 32'(k * 4) || rd_data !== mq[0]) begin
                failures++;
                $display("FAIL trig_any_pop%0d: valid=%b data=%h required pc=%h entry=%h",
                         k, rd_valid, rd_data, k * 4, mq[0]);
            end
            step();
        end
        checks++;
        if (rd_valid !== 1'b0 || count !== '0) begin
            failures++;
            $display("FAIL trig_any_drained: valid=%b count=%0d required 0/0", rd_valid, count);
        end
        rd_ready = 0;
    endtask

    task automatic test_trig_pc();
        do_clear();
        trig_any = 0;
        trig_pc = 32'h10;
        pc_i = 32'h0;
        do_arm();
        for (int k = 0; k < 4; k++) begin
            pc_i = 32'(k * 4);
            instr_i = $urandom;
            step();
            checks++;
            if (count !== '0 || state_o !== 2'd1) begin
                failures++;
                $display("FAIL trig_pc_wait%0d: count=%0d state=%0d required 0/1", k, count, state_o);
            end
        end
        pc_i = 32'h10;
        instr_i = $urandom;
        step();
        checks++;
        if (state_o !== 2'd2 || count !== 5'd1 || rd_data[63:32] !== 32'h10 || rd_data[31:0] !== instr_i) begin
            failures++;
            $display("FAIL trig_pc_hit: state=%0d count=%0d data=%h required 2/1/pc 00000010",
                     state_o, count, rd_data);
        end
        pc_i = 32'h14;
        stop = 1;
        step();
        stop = 0;
    endtask

    task automatic test_overflow();
        logic [31:0] want_pc;
        do_clear();
        trig_any = 1;
        do_arm();
        for (int k = 0; k < 20; k++) begin
            pc_i = 32'h1000 + 32'(k * 4);
            instr_i = $urandom;
            stop = (k == 19);
            step();
        end
        stop = 0;
`ifdef TRACE_WRAP_EN
        want_pc = 32'h1000 + 32'(4 * 4);
`else
        want_pc = 32'h1000;
`endif
        checks++;
        if (count !== 5'd16 || overflow !== 1'b1 || drop_cnt !== 4'd4 || rd_data[63:32] !== want_pc) begin
            failures++;
            $display("FAIL overflow: count=%0d ovf=%b drops=%0d first_pc=%h required 16/1/4/%h",
                     count, overflow, drop_cnt, rd_data[63:32], want_pc);
        end
        rd_ready = 1;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== mq[0]) begin
                failures++;
                $display("FAIL overflow_drain%0d: valid=%b data=%h required %h", j, rd_valid, rd_data, mq[0]);
            end
            step();
        end
        rd_ready = 0;
    endtask

    task automatic test_full_pop();
        do_clear();
        trig_any = 1;
        do_arm();
        for (int k = 0; k < 24; k++) begin
            pc_i = 32'h2000 + 32'(k * 4);
            instr_i = $urandom;
            rd_ready = (k >= 16);
            stop = (k == 23);
            step();
            if (k >= 15) begin
                checks++;
                if (count !== 5'd16 || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL full_pop%0d: count=%0d ovf=%b required 16/0", k, count, overflow);
                end
            end
        end
        stop = 0;
        rd_ready = 1;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (rd_data[63:32] !== 32'h2000 + 32'((8 + j) * 4)) begin
                failures++;
                $display("FAIL full_pop_order%0d: pc=%h required %h", j, rd_data[63:32], 32'h2000 + 32'((8 + j) * 4));
            end
            step();
        end
        rd_ready = 0;
    endtask

    task automatic test_clear_stop_reset();
        do_clear();
        trig_any = 1;
        do_arm();
        for (int k = 0; k < 18; k++) begin
            pc_i = 32'(k * 4);
            step();
        end
        clear = 1;
        stop = 1;
        rd_ready = 1;
        step();
        idle_inputs();
        checks++;
        if (state_o !== 2'd0 || count !== '0 || overflow !== 1'b0 || drop_cnt !== '0) begin
            failures++;
            $display("FAIL clear_stop: state=%0d count=%0d ovf=%b drops=%0d required 0/0/0/0",
                     state_o, count, overflow, drop_cnt);
        end
        do_arm();
        for (int k = 0; k < 18; k++) begin
            pc_i = 32'(k * 4);
            step();
        end
        reset = 0;
        #1;
        checks++;
        if (state_o !== 2'd0 || count !== '0 || rd_valid !== 1'b0 || overflow !== 1'b0 || drop_cnt !== '0) begin
            failures++;
            $display("FAIL async_reset: state=%0d count=%0d valid=%b ovf=%b drops=%0d required 0/0/0/0/0",
                     state_o, count, rd_valid, overflow, drop_cnt);
        end
        @(posedge clk);
        #1;
        reset = 1;
        model_reset();
    endtask

    task automatic test_saturate();
        do_clear();
        trig_any = 1;
        do_arm();
        for (int k = 0; k < 36; k++) begin
            pc_i = 32'(k * 4);
            instr_i = $urandom;
            stop = (k == 35);
            step();
        end
        stop = 0;
        checks++;
        if (drop_cnt !== 4'd15 || overflow !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL saturate: drops=%0d ovf=%b count=%0d required 15/1/16", drop_cnt, overflow, count);
        end
    endtask

    task automatic test_random();
        do_clear();
        trig_pc = 32'h10;
        for (int c = 0; c < 3000; c++) begin
            clear    = ($urandom_range(0, 99) < 2);
            stop     = ($urandom_range(0, 99) < 5);
            arm      = ($urandom_range(0, 99) < 10);
            trig_any = ($urandom_range(0, 99) < 30);
            rd_ready = ($urandom_range(0, 99) < 45);
            pc_i     = 32'($urandom_range(0, 15)) << 2;
            instr_i  = $urandom;
            step();
            checks++;
            if (state_o !== 2'(mst) || count !== (AW+1)'(mq.size()) || rd_valid !== (mq.size() > 0) ||
                overflow !== movf || drop_cnt !== DROP_W'(mdrops) ||
                (mq.size() > 0 && rd_data !== mq[0])) begin
                failures++;
                $display("FAIL random%0d: state=%0d/%0d count=%0d/%0d ovf=%b/%b drops=%0d/%0d data=%h/%h",
                         c, state_o, mst, count, mq.size(), overflow, movf, drop_cnt, mdrops,
                         rd_data, (mq.size() > 0) ? mq[0] : 64'h0);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_trig_any();
        test_trig_pc();
        test_overflow();
        test_full_pop();
        test_clear_stop_reset();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
